// File: rtl/oversampling_oserdes_halfperiod_generator_if.sv
// Period handshake and parallel sample outputs of the OSERDES half-period generator.
// The master drives periods and observes the word stream; the slave is the generator itself.
interface oversampling_oserdes_halfperiod_generator_if #(
  parameter int PERIOD_BITS = 16
);
  logic [PERIOD_BITS-1:0] PERIOD_IN;
  logic                   PERIOD_VALID;
  logic                   PERIOD_READY;
  logic [7:0]             DATA_OUT;
  logic                   EDGE_FLAG;
  logic [2:0]             EDGE_POS;
  logic                   UNDERRUN;

  modport master (
    output PERIOD_IN,
    output PERIOD_VALID,
    input  PERIOD_READY,
    input  DATA_OUT,
    input  EDGE_FLAG,
    input  EDGE_POS,
    input  UNDERRUN
  );

  modport slave (
    input  PERIOD_IN,
    input  PERIOD_VALID,
    output PERIOD_READY,
    output DATA_OUT,
    output EDGE_FLAG,
    output EDGE_POS,
    output UNDERRUN
  );
endinterface

// File: rtl/oversampling_oserdes_halfperiod_generator.sv
// Square-wave synthesizer: turns half-period values (1/8-clock sample units) into 8-sample
// parallel words for an 8:1 OSERDES, bit 0 being the earliest sample on the line.
module oversampling_oserdes_halfperiod_generator #(
  parameter int PERIOD_BITS = 16,
  parameter int MIN_HALF    = 8
) (
  input  logic CLK_PARALLEL,
  input  logic RESETN,
  input  logic CE,
  oversampling_oserdes_halfperiod_generator_if.slave bus
);

  localparam logic [PERIOD_BITS-1:0] WORD_SAMPLES = PERIOD_BITS'(8);
  localparam logic [PERIOD_BITS-1:0] MIN_HALF_P   = PERIOD_BITS'(MIN_HALF);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t                 state_reg;
  logic                   level_reg;
  logic [PERIOD_BITS-1:0] r_reg;
  logic [PERIOD_BITS-1:0] hold_reg;
  logic                   hold_valid_reg;
  logic [PERIOD_BITS-1:0] last_reg;
  logic [7:0]             data_reg;
  logic                   edge_flag_reg;
  logic [2:0]             edge_pos_reg;
  logic                   underrun_reg;

  logic                   transfer;
  logic [PERIOD_BITS-1:0] period_clamped;
  logic                   edge_in_word;
  logic [7:0]             edge_word;
  logic [PERIOD_BITS-1:0] next_period;
  logic                   next_is_underrun;

  assign bus.PERIOD_READY = RESETN & ~hold_valid_reg;
  assign transfer         = bus.PERIOD_VALID & bus.PERIOD_READY;
  assign period_clamped   = (bus.PERIOD_IN < MIN_HALF_P) ? MIN_HALF_P : bus.PERIOD_IN;
  assign edge_in_word     = (r_reg < WORD_SAMPLES);

  // Samples before the edge keep the current level; from index r on the line is inverted.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_edge_word
      assign edge_word[gi] = (3'(gi) < r_reg[2:0]) ? level_reg : ~level_reg;
    end
  endgenerate

  // Next half-period at an edge: buffered value, else same-cycle bypass, else repeat last.
  always_comb begin
    next_period      = last_reg;
    next_is_underrun = 1'b0;
    if (hold_valid_reg) begin
      next_period = hold_reg;
    end else if (transfer) begin
      next_period = period_clamped;
    end else begin
      next_is_underrun = 1'b1;
    end
  end

  always_ff @(posedge CLK_PARALLEL) begin
    if (!RESETN) begin
      state_reg      <= ST_IDLE;
      level_reg      <= 1'b0;
      r_reg          <= '0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      last_reg       <= MIN_HALF_P;
      data_reg       <= 8'h00;
      edge_flag_reg  <= 1'b0;
      edge_pos_reg   <= 3'd0;
      underrun_reg   <= 1'b0;
    end else begin
      data_reg      <= {8{level_reg}};
      edge_flag_reg <= 1'b0;
      edge_pos_reg  <= 3'd0;
      underrun_reg  <= 1'b0;

      // Transfer only happens with an empty buffer, so it never races a consume below.
      if (transfer) begin
        hold_reg       <= period_clamped;
        hold_valid_reg <= 1'b1;
      end

      if (CE) begin
        case (state_reg)
          ST_IDLE: begin
            if (hold_valid_reg) begin
              r_reg          <= hold_reg;
              last_reg       <= hold_reg;
              hold_valid_reg <= 1'b0;
              state_reg      <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (!edge_in_word) begin
              r_reg <= r_reg - WORD_SAMPLES;
            end else begin
              data_reg       <= edge_word;
              level_reg      <= ~level_reg;
              edge_flag_reg  <= 1'b1;
              edge_pos_reg   <= r_reg[2:0];
              underrun_reg   <= next_is_underrun;
              r_reg          <= next_period - (WORD_SAMPLES - r_reg);
              last_reg       <= next_period;
              // Covers both consuming the buffer and a bypassed transfer that must not be stored.
              hold_valid_reg <= 1'b0;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.DATA_OUT  = data_reg;
  assign bus.EDGE_FLAG = edge_flag_reg;
  assign bus.EDGE_POS  = edge_pos_reg;
  assign bus.UNDERRUN  = underrun_reg;

endmodule

// File: tb/tb_oversampling_oserdes_halfperiod_generator.sv
// Bench for the OSERDES half-period generator: directed scenarios plus random traffic,
// compared cycle by cycle against an absolute-sample-time waveform model.
module tb_oversampling_oserdes_halfperiod_generator;

  localparam int PB = 16;

  logic CLK_PARALLEL = 1'b0;
  logic RESETN;
  logic CE;

  oversampling_oserdes_halfperiod_generator_if #(.PERIOD_BITS(PB)) bus ();

  oversampling_oserdes_halfperiod_generator #(
    .PERIOD_BITS(PB),
    .MIN_HALF   (8)
  ) dut (
    .CLK_PARALLEL(CLK_PARALLEL),
    .RESETN      (RESETN),
    .CE          (CE),
    .bus         (bus)
  );

  always #5 CLK_PARALLEL = ~CLK_PARALLEL;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Model: the line waveform in absolute sample time since the last load.
  bit     m_run;
  bit     m_level;
  longint m_t_edge;  // absolute sample index of the next edge
  longint m_w;       // index of the next word to be emitted in RUN
  longint m_hold;
  bit     m_hv;
  longint m_last;
  logic [7:0] e_data;
  logic       e_edge;
  logic [2:0] e_pos;
  logic       e_und;

  task automatic model_reset();
    m_run = 0; m_level = 0; m_t_edge = 0; m_w = 0;
    m_hold = 0; m_hv = 0; m_last = 8;
    e_data = 8'h00; e_edge = 0; e_pos = 0; e_und = 0;
  endtask

  task automatic model_step(input bit rstn, input bit ce, input bit valid, input longint pin);
    bit     xfer;
    bit     bypass;
    longint pc;
    longint lo;
    longint pos;
    longint n;
    if (!rstn) begin
      model_reset();
      return;
    end
    xfer   = valid && !m_hv;
    pc     = (pin < 8) ? 8 : pin;
    bypass = 0;
    e_data = {8{m_level}};
    e_edge = 0; e_pos = 0; e_und = 0;
    if (ce) begin
      if (!m_run) begin
        if (m_hv) begin
          m_run = 1; m_t_edge = m_hold; m_w = 0; m_last = m_hold; m_hv = 0;
        end
      end else begin
        lo = m_w * 8;
        if (m_t_edge < lo + 8) begin
          pos = m_t_edge - lo;
          for (int i = 0; i < 8; i++) e_data[i] = (i < pos) ? m_level : ~m_level;
          e_edge  = 1;
          e_pos   = 3'(pos);
          m_level = ~m_level;
          if (m_hv) begin
            n = m_hold; m_hv = 0;
          end else if (xfer) begin
            n = pc; bypass = 1;
          end else begin
            n = m_last; e_und = 1;
          end
          m_t_edge = m_t_edge + n;
          m_last   = n;
        end
        m_w++;
      end
    end
    if (xfer && !bypass) begin
      m_hold = pc; m_hv = 1;
    end
  endtask

  // One clock cycle: drive, check READY, clock, update model, check registered outputs.
  task automatic step(input bit rstn, input bit ce, input bit valid, input logic [PB-1:0] pin);
    RESETN           = rstn;
    CE               = ce;
    bus.PERIOD_VALID = valid;
    bus.PERIOD_IN    = pin;
    #1;
    check("ready", 32'(bus.PERIOD_READY), 32'(rstn && !m_hv));
    @(posedge CLK_PARALLEL);
    model_step(rstn, ce, valid, longint'(pin));
    #1;
    check("data", 32'(bus.DATA_OUT), 32'(e_data));
    check("edge_flag", 32'(bus.EDGE_FLAG), 32'(e_edge));
    check("edge_pos", 32'(bus.EDGE_POS), 32'(e_pos));
    check("underrun", 32'(bus.UNDERRUN), 32'(e_und));
  endtask

  initial begin
    logic [7:0] first_edge_data;
    logic [2:0] first_edge_pos;
    bit         seen_edge;
    int         und_count;
    logic [PB-1:0] pin;

    model_reset();
    RESETN = 0; CE = 1; bus.PERIOD_VALID = 0; bus.PERIOD_IN = '0;
    @(negedge CLK_PARALLEL);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    // Half-period 20 held valid: first edge lands at sample 4 of its word.
    seen_edge = 0; und_count = 0;
    first_edge_data = 8'h00; first_edge_pos = 3'd0;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 1, 16'd20);
      if (bus.EDGE_FLAG && !seen_edge) begin
        seen_edge = 1; first_edge_data = bus.DATA_OUT; first_edge_pos = bus.EDGE_POS;
      end
      if (bus.UNDERRUN) und_count++;
    end
    check("t1_first_edge_word", 32'(first_edge_data), 32'h0000_00F0);
    check("t1_first_edge_pos", 32'(first_edge_pos), 32'd4);
    check("t1_underruns", 32'(und_count), 32'd0);

    // Too-short periods are clamped to 8: one edge per word at position 0.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 1, (i % 2 == 0) ? 16'd5 : 16'd0);

    // Load 12 once, then let it underrun repeatedly.
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0);
    step(1, 1, 1, 16'd12);
    und_count = 0;
    for (int i = 0; i < 24; i++) begin
      step(1, 1, 0, 0);
      if (bus.UNDERRUN) und_count++;
    end
    check("t3_underrun_seen", 32'(und_count > 10), 32'd1);

    // Bypass: offer 10 only in cycles whose word contains the edge (hold is empty).
    for (int i = 0; i < 24; i++) begin
      if (m_run && !m_hv && (m_t_edge < m_w * 8 + 8)) step(1, 1, 1, 16'd10);
      else step(1, 1, 0, 0);
    end

    // Clock enable gaps mid-run while the handshake keeps working.
    for (int i = 0; i < 30; i++) step(1, (i % 7) > 2, (i % 3) == 0, 16'd13 + 16'(i));

    // Reset with a full hold register.
    step(1, 1, 1, 16'd30);
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: pin = 16'($urandom_range(0, 9));
        1: pin = 16'($urandom_range(8, 24));
        2: pin = 16'($urandom_range(25, 120));
        default: pin = 16'($urandom_range(0, 40));
      endcase
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 2) != 0), pin);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
